// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types for the I2S audio transmit path
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 16;

  typedef logic signed [AUDIO_SAMPLE_W-1:0] audio_sample_t;

  typedef enum logic [1:0] {TX_IDLE, TX_RUN, TX_STOP} i2s_tx_state_t;

endpackage

// File: rtl/i2s_audio_tx_if.sv
// rtl/i2s_audio_tx_if.sv - PCM sample handshake between tone source and I2S serializer
interface i2s_audio_tx_if
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = AUDIO_SAMPLE_W
);

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic                sample_req;
  logic                underrun;

  modport master (
    output sample_in, sample_valid,
    input  sample_ready, sample_req, underrun
  );

  modport slave (
    input  sample_in, sample_valid,
    output sample_ready, sample_req, underrun
  );

endinterface

// File: rtl/aud_bclk_gen.sv
// rtl/aud_bclk_gen.sv - BCLK divider with fall/rise strobes aligned to the BCLK edge cycle
module aud_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bclk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  // Strobes are high in the clk whose edge toggles bclk, so registers
  // updated on the strobe change together with the BCLK edge.
  assign wrap     = run && (cnt == CW'(BCLK_DIV - 1));
  assign fall_stb = wrap && bclk;
  assign rise_stb = wrap && !bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      bclk <= !bclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - mono-to-stereo I2S serializer with one-entry holding register
// Optional saturating underrun counter port enabled by AUDIO_TX_UNDERRUN_CNT_EN.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = AUDIO_SAMPLE_W,
  parameter int SLOT_W   = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          enable,
  i2s_audio_tx_if.slave smp,
  output logic          AUD_BCLK,
  output logic          AUD_DACLRCK,
  output logic          AUD_DACDAT
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]    underrun_cnt
`endif
);

  localparam int PW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

  i2s_tx_state_t       state;
  logic [PW-1:0]       pos;
  logic [PW-1:0]       pos_next;
  logic [SAMPLE_W-1:0] hold;
  logic [SAMPLE_W-1:0] shift;
  logic                full;
  logic                full_next;
  logic                fall_stb;
  logic                rise_stb;
  logic                wrap;
  logic                frame_start;
  logic                load;
  logic                drain;
  logic                bit_next;

  aud_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk      (clk),
    .rst_n    (resetN),
    .run      (state != TX_IDLE),
    .bclk     (AUD_BCLK),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  // A STOP frame that regains enable before its last fall simply continues.
  assign wrap        = fall_stb && AUD_DACLRCK && (pos == PW'(SLOT_W - 1));
  assign frame_start = ((state == TX_IDLE) && enable) ||
                       (wrap && ((state == TX_RUN) || enable));
  assign load        = smp.sample_valid && smp.sample_ready;
  assign drain       = frame_start && full;
  assign full_next   = load || (full && !drain);

  // One-BCLK I2S delay: slot position 0 still carries the last word's LSB.
  always_comb begin
    pos_next = (pos == PW'(SLOT_W - 1)) ? '0 : pos + 1'b1;
    bit_next = 1'b0;
    if (pos_next == '0) begin
      bit_next = shift[0];
    end else begin
      for (int i = 0; i < SAMPLE_W; i++) begin
        if (int'(pos_next) == SAMPLE_W - i) bit_next = shift[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= TX_IDLE;
      pos              <= '0;
      AUD_DACLRCK      <= 1'b1;
      AUD_DACDAT       <= 1'b0;
      hold             <= '0;
      shift            <= '0;
      full             <= 1'b0;
      smp.sample_ready <= 1'b1;
      smp.sample_req   <= 1'b0;
      smp.underrun     <= 1'b0;
    end else begin
      smp.sample_req   <= drain;
      smp.underrun     <= frame_start && !full;
      full             <= full_next;
      smp.sample_ready <= !full_next;
      if (load)  hold  <= smp.sample_in;
      if (drain) shift <= hold;
      case (state)
        TX_IDLE: begin
          if (enable) begin
            state       <= TX_RUN;
            pos         <= '0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
          end
        end
        default: begin
          if (enable)               state <= TX_RUN;
          else if (state == TX_RUN) state <= TX_STOP;
          if (fall_stb) begin
            if (wrap && !frame_start) begin
              state      <= TX_IDLE;
              pos        <= '0;
              AUD_DACDAT <= 1'b0;
            end else begin
              pos        <= pos_next;
              AUD_DACDAT <= bit_next;
              if (pos_next == '0) AUD_DACLRCK <= !AUD_DACLRCK;
            end
          end
        end
      endcase
    end
  end

`ifdef AUDIO_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      underrun_cnt <= 8'h00;
    end else if (frame_start && !full && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'h01;
    end
  end
`endif

endmodule
